arvi_bus_arbiter: RTL and testbench

// - Shares one bus_if slave port (memory/peripheral side) among N_MASTERS bus_if masters (e.g. I-fetch, D-mem, debug).
// - Registered grant, round-robin or fixed priority; grant held until slave i_ack; atomic lock keeps the bus across an LR/SC or AMO sequence.
// - Sits between core/cache bus masters and the single system bus slave.

---
 rtl/arvi_pkg.sv | 18 +
 rtl/arvi_rr_picker.sv | 37 +++
 rtl/arvi_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_arvi_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_pkg.sv
// arvi bus arbiter shared types.
// FSM state encoding and index-width helper.
package arvi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY   = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_t;

  localparam int ARB_MAX_MASTERS = 8;

  // Index width for n masters, never below 1 bit.
  function automatic int arb_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arvi_rr_picker.sv
// Rotating priority encoder for the bus arbiter.
// Search starts at ptr (0 in fixed-priority mode).
module arvi_rr_picker
  import arvi_pkg::*;
#(
  parameter int N         = 2,
  parameter int PRIO_MODE = 0,
  localparam int IW       = arb_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int start;
  int k;

  // First requester at or after the start index wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    start = (PRIO_MODE == 1) ? 0 : int'(ptr);
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (start + i) % N;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/arvi_bus_arbiter.sv
// Shares one bus slave among N masters.
// Registered grant, RR or fixed priority, atomic lock.
module arvi_bus_arbiter
  import arvi_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int PRIO_MODE = 0,
  parameter bit ATOMIC_EN = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [N_MASTERS-1:0]   i_m_bus_en,
  input  logic [N_MASTERS-1:0]   i_m_wr_en,
  input  logic [32*N_MASTERS-1:0] i_m_addr,
  input  logic [32*N_MASTERS-1:0] i_m_wr_data,
  input  logic [4*N_MASTERS-1:0] i_m_byte_en,
  input  logic [7*N_MASTERS-1:0] i_m_operation,
  input  logic [N_MASTERS-1:0]   i_m_atomic,
  output logic [N_MASTERS-1:0]   o_m_ack,
  output logic [32*N_MASTERS-1:0] o_m_rd_data,
  output logic                   o_s_bus_en,
  output logic                   o_s_wr_en,
  output logic [31:0]            o_s_addr,
  output logic [31:0]            o_s_wr_data,
  output logic [3:0]             o_s_byte_en,
  output logic [6:0]             o_s_operation,
  output logic                   o_s_atomic,
  input  logic                   i_s_ack,
  input  logic [31:0]            i_s_rd_data,
  output logic [N_MASTERS-1:0]   o_grant
);

  localparam int N  = N_MASTERS;
  localparam int IW = arb_idx_w(N);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [IW-1:0] pick_ptr;
  logic [IW-1:0] ptr_next;
  logic          busy;
  logic          req_g;
  logic          atom_g;

  assign pick_ptr = (PRIO_MODE == 1) ? '0 : ptr_q;
  assign busy     = (state_q == ARB_BUSY);
  assign req_g    = i_m_bus_en[idx_q];
  assign atom_g   = ATOMIC_EN && i_m_atomic[idx_q];
  assign ptr_next = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
  assign o_grant  = grant_q;

  arvi_rr_picker #(
    .N        (N),
    .PRIO_MODE(PRIO_MODE)
  ) u_picker (
    .req  (i_m_bus_en),
    .ptr  (pick_ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  // State, grant and round-robin pointer registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: arbitrate in IDLE, hold grant through BUSY/LOCKED.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
          idx_d   = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!req_g) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end else if (i_s_ack) begin
          ptr_d = ptr_next;
          if (atom_g) begin
            state_d = ARB_LOCKED;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      ARB_LOCKED: begin
        if (req_g) begin
          state_d = ARB_BUSY;
        end else if (!atom_g) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Request mux to the slave and response demux to the owner.
  always_comb begin
    o_s_bus_en    = 1'b0;
    o_s_wr_en     = 1'b0;
    o_s_addr      = '0;
    o_s_wr_data   = '0;
    o_s_byte_en   = '0;
    o_s_operation = '0;
    o_s_atomic    = 1'b0;
    o_m_ack       = '0;
    o_m_rd_data   = '0;
    for (int k = 0; k < N; k++) begin
      if (busy && grant_q[k]) begin
        o_s_bus_en    = i_m_bus_en[k];
        o_s_wr_en     = i_m_wr_en[k];
        o_s_addr      = i_m_addr[32*k +: 32];
        o_s_wr_data   = i_m_wr_data[32*k +: 32];
        o_s_byte_en   = i_m_byte_en[4*k +: 4];
        o_s_operation = ATOMIC_EN ? i_m_operation[7*k +: 7] : '0;
        o_s_atomic    = ATOMIC_EN && i_m_atomic[k];
        o_m_ack[k]    = i_s_ack && i_m_bus_en[k];
        o_m_rd_data[32*k +: 32] = i_s_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_arvi_bus_arbiter.sv
// Bench for arvi_bus_arbiter: RR and fixed-priority
// instances checked against an owner/lock/pointer model.
module tb_arvi_bus_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] bus_en, wr_en, atomic;
  logic [63:0]  addr, wdata;
  logic [7:0]   be;
  logic [13:0]  op;
  logic         s_ack;
  logic [31:0]  s_rd;

  logic [1:0][1:0]  g_grant;
  logic [1:0][1:0]  m_ack;
  logic [1:0][63:0] m_rd;
  logic [1:0]       s_en, s_we, s_at;
  logic [1:0][31:0] s_addr, s_wd;
  logic [1:0][3:0]  s_be;
  logic [1:0][6:0]  s_op;

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar j = 0; j < 2; j++) begin : g_dut
    arvi_bus_arbiter #(
      .N_MASTERS(N),
      .PRIO_MODE(j),
      .ATOMIC_EN(1'b1)
    ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_m_bus_en   (bus_en),
      .i_m_wr_en    (wr_en),
      .i_m_addr     (addr),
      .i_m_wr_data  (wdata),
      .i_m_byte_en  (be),
      .i_m_operation(op),
      .i_m_atomic   (atomic),
      .o_m_ack      (m_ack[j]),
      .o_m_rd_data  (m_rd[j]),
      .o_s_bus_en   (s_en[j]),
      .o_s_wr_en    (s_we[j]),
      .o_s_addr     (s_addr[j]),
      .o_s_wr_data  (s_wd[j]),
      .o_s_byte_en  (s_be[j]),
      .o_s_operation(s_op[j]),
      .o_s_atomic   (s_at[j]),
      .i_s_ack      (s_ack),
      .i_s_rd_data  (s_rd),
      .o_grant      (g_grant[j])
    );
  end

  // Model: who owns the bus (-1 none), whether the owner
  // is between atomic accesses, and the RR start index.
  int own [2] = '{-1, -1};
  int lk  [2] = '{0, 0};
  int ptr [2] = '{0, 0};

  function automatic int winner(int j, logic [1:0] req, int p);
    int s;
    s = (j == 1) ? 0 : p;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (s + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < 2; j++) begin
        own[j] <= -1;
        lk[j]  <= 0;
        ptr[j] <= 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        int o, l, p;
        o = own[j];
        l = lk[j];
        p = ptr[j];
        if (o < 0) begin
          o = winner(j, bus_en, p);
        end else if (l == 0) begin
          if (!bus_en[o]) o = -1;
          else if (s_ack) begin
            p = (o + 1) % N;
            if (atomic[o]) l = 1;
            else o = -1;
          end
        end else begin
          if (bus_en[o]) l = 0;
          else if (!atomic[o]) begin
            o = -1;
            l = 0;
          end
        end
        own[j] <= o;
        lk[j]  <= l;
        ptr[j] <= p;
      end
    end
  end

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      logic [1:0]   eg, ea;
      logic [63:0]  erd;
      logic         een, ewe, eat;
      logic [31:0]  ead, ewd;
      logic [3:0]   ebe;
      logic [6:0]   eop;
      logic [145:0] exp_v, got_v;
      int o;
      eg = '0; ea = '0; erd = '0; een = 0; ewe = 0; eat = 0;
      ead = '0; ewd = '0; ebe = '0; eop = '0;
      o = own[j];
      if (o >= 0) eg[o] = 1'b1;
      if (o >= 0 && lk[j] == 0) begin
        een = bus_en[o];
        ewe = wr_en[o];
        ead = addr[32*o +: 32];
        ewd = wdata[32*o +: 32];
        ebe = be[4*o +: 4];
        eop = op[7*o +: 7];
        eat = atomic[o];
        ea[o] = s_ack & bus_en[o];
        erd[32*o +: 32] = s_rd;
      end
      exp_v = {eg, ea, erd, een, ewe, ead, ewd, ebe, eop, eat};
      got_v = {g_grant[j], m_ack[j], m_rd[j], s_en[j], s_we[j],
               s_addr[j], s_wd[j], s_be[j], s_op[j], s_at[j]};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cmp[%0d] t=%0t got %h want %h",
                 j, $time, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_seq [$];
  logic [1:0] fp_seq [$];

  initial begin
    bus_en = '0; wr_en = '0; atomic = '0;
    addr = '0; wdata = '0; be = '0; op = '0;
    s_ack = 1'b0; s_rd = '0;

    @(negedge clk);
    chk("rst_grant_rr", 64'(g_grant[0]), 64'd0);
    chk("rst_grant_fp", 64'(g_grant[1]), 64'd0);
    chk("rst_s_en", 64'(s_en), 64'd0);
    tick();
    rstn = 1'b1;

    // single master read
    tick();
    bus_en = 2'b01;
    addr   = {32'h0000_5000, 32'h0000_0100};
    @(negedge clk);
    chk("lat_idle", 64'(g_grant[0]), 64'd0);
    tick();
    @(negedge clk);
    chk("rd_s_en", 64'(s_en[0]), 64'd1);
    chk("rd_grant", 64'(g_grant[0]), 64'd1);
    chk("rd_addr", 64'(s_addr[0]), 64'h100);
    tick();
    tick();
    s_ack = 1'b1;
    s_rd  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_ack", 64'(m_ack[0]), 64'b01);
    chk("rd_data_m0", 64'(m_rd[0][31:0]), 64'hDEAD_BEEF);
    chk("rd_data_m1", 64'(m_rd[0][63:32]), 64'd0);
    tick();
    bus_en = '0;
    s_ack  = 1'b0;
    s_rd   = '0;
    @(negedge clk);
    chk("rd_done", 64'(g_grant[0]), 64'd0);

    // fairness: both request, slave acks at once
    tick();
    bus_en = 2'b11;
    s_ack  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (g_grant[0] != 0) rr_seq.push_back(g_grant[0]);
      if (g_grant[1] != 0) fp_seq.push_back(g_grant[1]);
      tick();
    end
    bus_en = '0;
    s_ack  = 1'b0;
    chk("rr_count", 64'(rr_seq.size()), 64'd4);
    chk("fp_count", 64'(fp_seq.size()), 64'd4);
    for (int i = 0; i < 4 && i < rr_seq.size(); i++)
      chk("rr_alt", 64'(rr_seq[i]), (i % 2 == 0) ? 64'd2 : 64'd1);
    for (int i = 0; i < 4 && i < fp_seq.size(); i++)
      chk("fp_m0", 64'(fp_seq[i]), 64'd1);

    // abort by m1
    tick();
    bus_en = 2'b10;
    tick();
    bus_en = 2'b00;
    @(negedge clk);
    chk("ab_grant", 64'(g_grant[0]), 64'd2);
    chk("ab_s_en", 64'(s_en[0]), 64'd0);
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("ab_idle", 64'(g_grant[0]), 64'd0);
    chk("ab_late_ack", 64'({m_ack[1], m_ack[0]}), 64'd0);
    tick();
    s_ack  = 1'b0;
    bus_en = 2'b11;
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("ab_ptr_rr", 64'(g_grant[0]), 64'd2);
    chk("ab_ptr_fp", 64'(g_grant[1]), 64'd1);
    chk("ab_ack_rr", 64'(m_ack[0]), 64'b10);
    tick();
    bus_en = '0;
    s_ack  = 1'b0;

    // atomic lock by m0 with m1 waiting
    tick();
    bus_en = 2'b11;
    atomic = 2'b01;
    op     = {7'h7F, 7'h02};
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("lr_grant", 64'(g_grant[0]), 64'd1);
    chk("lr_atomic", 64'(s_at[0]), 64'd1);
    chk("lr_op", 64'(s_op[0]), 64'h02);
    tick();
    bus_en = 2'b10;
    s_ack  = 1'b0;
    @(negedge clk);
    chk("lk_grant", 64'(g_grant[0]), 64'd1);
    chk("lk_s_en", 64'(s_en[0]), 64'd0);
    tick();
    bus_en = 2'b11;
    op     = {7'h7F, 7'h03};
    @(negedge clk);
    chk("lk_hold", 64'(g_grant[0]), 64'd1);
    tick();
    atomic = 2'b00;
    s_ack  = 1'b1;
    @(negedge clk);
    chk("sc_grant", 64'(g_grant[0]), 64'd1);
    chk("sc_s_en", 64'(s_en[0]), 64'd1);
    chk("sc_op", 64'(s_op[0]), 64'h03);
    chk("sc_ack", 64'(m_ack[0]), 64'b01);
    tick();
    bus_en = 2'b10;
    s_ack  = 1'b0;
    @(negedge clk);
    chk("ul_idle", 64'(g_grant[0]), 64'd0);
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("ul_m1", 64'(g_grant[0]), 64'd2);
    tick();
    bus_en = '0;
    s_ack  = 1'b0;
    op     = '0;

    // write by m1
    tick();
    bus_en = 2'b10;
    wr_en  = 2'b10;
    addr   = {32'h0000_2000, 32'hAAAA_0000};
    wdata  = {32'h0000_0F0F, 32'h5555_5555};
    be     = {4'b0011, 4'b1111};
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    chk("wr_addr", 64'(s_addr[0]), 64'h2000);
    chk("wr_data", 64'(s_wd[0]), 64'h0F0F);
    chk("wr_be", 64'(s_be[0]), 64'h3);
    chk("wr_en", 64'(s_we[0]), 64'd1);
    tick();
    bus_en = '0;
    wr_en  = '0;
    s_ack  = 1'b0;

    // async reset in the middle of a transfer
    tick();
    bus_en = 2'b01;
    addr   = {32'h0, 32'h0000_0300};
    tick();
    chk("rs_pre", 64'(s_en[0]), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rs_s_en", 64'(s_en), 64'd0);
    chk("rs_grant_rr", 64'(g_grant[0]), 64'd0);
    chk("rs_grant_fp", 64'(g_grant[1]), 64'd0);
    bus_en = 2'b10;
    tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    chk("rs_m1_rr", 64'(g_grant[0]), 64'd2);
    chk("rs_m1_fp", 64'(g_grant[1]), 64'd2);
    tick();
    bus_en = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
